// File: rtl/led_sequencer.sv
// LED pattern sequencer: debounced start/clear buttons drive a run/pause/idle FSM,
// a prescaler paces steps of a four-mode pattern that is masked onto the LED bank.
module led_sequencer #(
   parameter int unsigned WIDTH         = 24,
   parameter int unsigned PRESCALE      = 50000000,
   parameter int unsigned DEBOUNCE_BITS = 17
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic             clear,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] SEL,
   output logic [WIDTH-1:0] LED,
   output logic             running,
   output logic             wrap
);
   localparam int unsigned      PW   = $clog2(PRESCALE);
   localparam int unsigned      DW   = DEBOUNCE_BITS;
   localparam logic [WIDTH-1:0] SEED = WIDTH'(1);
   localparam logic [PW-1:0]    LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] pattern, pattern_n, step_pat;
   logic             dir, dir_n, step_dir;
   logic [PW-1:0]    presc, presc_n;
   logic             wrap_n;
   logic             tick;

   logic [1:0]       btn_s1, btn_s2, btn_db;
   logic [DW-1:0]    btn_cnt [2];
   logic             start_press_c, clear_press_c;

   logic [1:0]       mode_s1, mode_s2, mode_q;
   logic             mode_chg;

   // Button debouncers: index 0 is start, index 1 is clear
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         btn_s1     <= '0;
         btn_s2     <= '0;
         btn_db     <= '0;
         btn_cnt[0] <= '0;
         btn_cnt[1] <= '0;
      end else begin
         btn_s1 <= {clear, start};
         btn_s2 <= btn_s1;
         for (int i = 0; i < 2; i++) begin
            if (btn_s2[i] == btn_db[i]) begin
               btn_cnt[i] <= '0;
            end else if (&btn_cnt[i]) begin
               btn_db[i]  <= ~btn_db[i];
               btn_cnt[i] <= '0;
            end else begin
               btn_cnt[i] <= btn_cnt[i] + DW'(1);
            end
         end
      end
   end

   assign start_press_c = btn_s2[0] & ~btn_db[0] & (&btn_cnt[0]);
   assign clear_press_c = btn_s2[1] & ~btn_db[1] & (&btn_cnt[1]);

   // Mode switch synchroniser and change detector
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mode_s1 <= 2'b00;
         mode_s2 <= 2'b00;
         mode_q  <= 2'b00;
      end else begin
         mode_s1 <= mode;
         mode_s2 <= mode_s1;
         mode_q  <= mode_s2;
      end
   end

   assign mode_chg = (mode_s2 != mode_q);
   assign tick     = (state == S_RUN) && (presc == LAST);

   // One step of the current mode; dir=1 means moving right in bounce mode
   always_comb begin
      step_pat = pattern;
      step_dir = dir;
      case (mode_q)
         2'b00: step_pat = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
         2'b01: step_pat = {pattern[0], pattern[WIDTH-1:1]};
         2'b10: begin
            if (!dir) begin
               step_pat = pattern << 1;
               if (step_pat[WIDTH-1]) step_dir = 1'b1;
            end else begin
               step_pat = pattern >> 1;
               if (step_pat[0]) step_dir = 1'b0;
            end
         end
         default: step_pat = (&pattern) ? SEED : {pattern[WIDTH-2:0], 1'b1};
      endcase
   end

   // Next state and datapath; clear overrides everything, reseed overrides a step
   always_comb begin
      state_n   = state;
      pattern_n = pattern;
      dir_n     = dir;
      presc_n   = presc;
      wrap_n    = 1'b0;
      case (state)
         S_IDLE: begin
            presc_n   = '0;
            pattern_n = SEED;
            dir_n     = 1'b0;
            if (start_press_c) state_n = S_RUN;
         end
         S_RUN: begin
            presc_n = tick ? '0 : presc + PW'(1);
            if (start_press_c) state_n = S_PAUSE;
         end
         S_PAUSE: begin
            if (start_press_c) state_n = S_RUN;
         end
         default: state_n = S_IDLE;
      endcase
      if (mode_chg) begin
         pattern_n = SEED;
         dir_n     = 1'b0;
      end else if (tick) begin
         pattern_n = step_pat;
         dir_n     = step_dir;
         wrap_n    = (step_pat == SEED);
      end
      if (clear_press_c) begin
         state_n   = S_IDLE;
         pattern_n = SEED;
         dir_n     = 1'b0;
         presc_n   = '0;
         wrap_n    = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         pattern <= SEED;
         dir     <= 1'b0;
         presc   <= '0;
         wrap    <= 1'b0;
         LED     <= '0;
         running <= 1'b0;
      end else begin
         state   <= state_n;
         pattern <= pattern_n;
         dir     <= dir_n;
         presc   <= presc_n;
         wrap    <= wrap_n;
         LED     <= SEL & pattern;
         running <= (state_n == S_RUN);
      end
   end

endmodule
